seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: registered anode/BCD strobing with blanking and frame-aligned double buffering.
// Optional leading-zero suppression when SEG_ZERO_BLANK_EN is defined.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    wr_valid,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic                    wr_ready,
  output logic [3:0]              num,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] BLANK_N   = TW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [1:0]              r_state;
  logic [TW-1:0]           r_tick;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic                    r_pend_vld;
  logic                    r_wr_ready;
  logic [3:0]              r_num;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic [1:0]              w_state_nxt;
  logic [TW-1:0]           w_tick_nxt;
  logic [IW-1:0]           w_idx_nxt;
  logic                    w_frame;
  logic                    w_accept;
  logic                    w_commit;
  logic [4*NUM_DIGITS-1:0] w_disp_nxt;
  logic [3:0]              w_digit;
  logic [NUM_DIGITS-1:0]   w_lit;
  logic [NUM_DIGITS-1:0]   w_an_nxt;

  assign wr_ready   = r_wr_ready;
  assign num        = r_num;
  assign an         = r_an;
  assign frame_done = r_frame_done;

  // Next scan position; outputs are registered from these so they line up with the counters.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_tick_nxt  = '0;
    w_idx_nxt   = '0;
    w_frame     = 1'b0;
    if (enable) begin
      if (r_state != S_IDLE) begin
        if (r_tick == TICK_LAST) begin
          w_tick_nxt = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = '0;
            w_frame   = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end else begin
          w_tick_nxt = r_tick + TW'(1);
          w_idx_nxt  = r_idx;
        end
      end
      w_state_nxt = (w_tick_nxt < BLANK_N) ? S_BLANK : S_DRIVE;
    end
  end

  assign w_accept   = wr_valid & r_wr_ready;
  assign w_commit   = r_pend_vld & (w_frame | ~enable);
  assign w_disp_nxt = w_commit ? r_pend : r_disp;

  always_comb begin
    w_digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_nxt == IW'(k)) w_digit = w_disp_nxt[4*k +: 4];
    end
  end

`ifdef SEG_ZERO_BLANK_EN
  // A digit is lit if it or any more significant digit is nonzero; digit 0 always lit.
  always_comb begin : p_lit
    logic seen;
    seen  = 1'b0;
    w_lit = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      seen     = seen | (w_disp_nxt[4*k +: 4] != 4'd0);
      w_lit[k] = seen;
    end
    w_lit[0] = 1'b1;
  end
`else
  assign w_lit = '1;
`endif

  always_comb begin
    w_an_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_state_nxt == S_DRIVE && w_idx_nxt == IW'(k) && w_lit[k]) w_an_nxt[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tick       <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_vld   <= 1'b0;
      r_wr_ready   <= 1'b0;
      r_num        <= 4'd0;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick       <= w_tick_nxt;
      r_idx        <= w_idx_nxt;
      r_disp       <= w_disp_nxt;
      r_num        <= w_digit;
      r_an         <= w_an_nxt;
      r_frame_done <= w_frame;
      if (w_accept) begin
        r_pend     <= wr_data;
        r_pend_vld <= 1'b1;
      end else if (w_commit) begin
        r_pend_vld <= 1'b0;
      end
      // Ready lags the commit by a cycle, so it reopens the cycle after the display swap.
      r_wr_ready <= w_accept ? 1'b0 : ~r_pend_vld;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic        wr_ready;
  logic [3:0]  num;
  logic [3:0]  an;
  logic        frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .num(num), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_frame;
    logic [3:0] an;
    logic [3:0] num;
    logic [7:0] gap;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_f = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Six drive cycles per lit digit, then a frame_done marker.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] lit, input logic [7:0] gap);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (lit[d]) begin
        for (int t = 0; t < 6; t++) begin
          e.is_frame = 1'b0;
          e.an       = ~(4'b0001 << d);
          e.num      = v[4*d +: 4];
          e.gap      = 8'd0;
          exp_q.push_back(e);
        end
      end
    end
    e.is_frame = 1'b1;
    e.an       = 4'hF;
    e.num      = 4'h0;
    e.gap      = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_drive(input logic [3:0] a, input logic [3:0] n, input int reps);
    exp_t e;
    for (int i = 0; i < reps; i++) begin
      e.is_frame = 1'b0;
      e.an       = a;
      e.num      = n;
      e.gap      = 8'd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    check("frame_wait", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    wr_data  = d;
    wr_valid = 1'b1;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {31'd0, wr_ready}, 32'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      cyc++;
      if (frame_done || an != 4'hF) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: an=%b num=%h frame_done=%b with nothing expected", an, num, frame_done);
        end else begin
          e = exp_q.pop_front();
          if (frame_done) begin
            if (!e.is_frame || (e.gap != 8'd0 && (cyc - last_f) != int'(e.gap))) begin
              errors++;
              $display("FAIL frame_event: got frame_done after %0d cycles, expected is_frame=%b an=%b num=%h gap=%0d",
                       cyc - last_f, e.is_frame, e.an, e.num, e.gap);
            end
            last_f = cyc;
          end else if (e.is_frame || an !== e.an || num !== e.num) begin
            errors++;
            $display("FAIL drive_event: got an=%b num=%h, expected is_frame=%b an=%b num=%h",
                     an, num, e.is_frame, e.an, e.num);
          end
        end
      end
    end
  end

  logic [3:0] m40, m00;

  initial begin
`ifdef SEG_ZERO_BLANK_EN
    m40 = 4'b0011;
    m00 = 4'b0001;
`else
    m40 = 4'b1111;
    m00 = 4'b1111;
`endif
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {22'd0, an, num, wr_ready, frame_done}, {22'd0, 4'hF, 4'h0, 1'b0, 1'b0});
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, wr_ready}, 32'd1);
    check("an_idle", {28'd0, an}, 32'hF);

    // Write while disabled commits immediately
    send(16'h1234);
    @(negedge clk);
    check("ready_low_after_accept", {31'd0, wr_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("ready_back_idle_commit", {31'd0, wr_ready}, 32'd1);

    push_frame(16'h1234, 4'hF, 8'd0);
    push_frame(16'h1234, 4'hF, 8'd32);
    enable = 1'b1;
    wait_frame();
    wait_frame();

    // Double buffer: 0x5678 pending, 0x9999 held off until the boundary
    push_frame(16'h1234, 4'hF, 8'd32);
    push_frame(16'h5678, 4'hF, 8'd32);
    push_frame(16'h9999, 4'hF, 8'd32);
    wr_data  = 16'h5678;
    wr_valid = 1'b1;
    @(negedge clk);
    check("ready_low_pending", {31'd0, wr_ready}, 32'd0);
    wr_data = 16'h9999;
    begin
      int hi, n;
      hi = 0;
      n  = 0;
      while (!frame_done && n < 100) begin
        if (wr_ready) hi++;
        @(negedge clk);
        n++;
      end
      check("ready_stayed_low", hi, 0);
      check("boundary_reached", {31'd0, frame_done}, 32'd1);
    end
    check("ready_low_on_boundary", {31'd0, wr_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_boundary", {31'd0, wr_ready}, 32'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    check("ready_low_9999", {31'd0, wr_ready}, 32'd0);
    wait_frame();
    wait_frame();

    // Drop enable during digit 2 drive (slot offset 19 = tick 3)
    push_drive(4'b1110, 4'h9, 6);
    push_drive(4'b1101, 4'h9, 6);
    push_drive(4'b1011, 4'h9, 2);
    repeat (19) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("an_off_after_disable", {28'd0, an}, 32'hF);
    check("no_frame_on_disable", {31'd0, frame_done}, 32'd0);

    send(16'h0040);
    @(negedge clk);
    check("ready_low_0040", {31'd0, wr_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("ready_back_0040", {31'd0, wr_ready}, 32'd1);
    repeat (30) @(negedge clk);

    push_frame(16'h0040, m40, 8'd0);
    push_frame(16'h0040, m40, 8'd32);
    push_frame(16'h0000, m00, 8'd32);
    push_frame(16'hAB0F, 4'hF, 8'd32);
    enable = 1'b1;
    wait_frame();
    send(16'h0000);
    wait_frame();
    send(16'hAB0F);
    wait_frame();
    wait_frame();
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
